// File: rtl/button_scan_pkg.sv
// Shared types and constants for the push-button PIO scanner.
package button_scan_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POLL = 3'd1,
        WAIT = 3'd2,
        CAPT = 3'd3,
        EMIT = 3'd4
    } scan_state_t;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_EVENT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int EVT_VALID = 31;
    localparam int EVT_TYPE  = 8;
    localparam int EVT_IDX_W = 4;

endpackage

// File: rtl/scan_event_fifo.sv
// Synchronous show-ahead event FIFO; a push that finds it full (without a pop) is dropped and flagged.
module scan_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so push+pop while full both succeed.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/button_pio_scanner.sv
// Polls the button PIO, debounces each bit and queues press/release events for the CPU.
module button_pio_scanner
    import button_scan_pkg::*;
#(
    parameter int NBITS        = 4,
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);
    localparam int         TW      = $clog2(POLL_DIV);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

    scan_state_t      state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic             tick;
    logic [NBITS-1:0] stable_q, stable_d;
    logic [NBITS-1:0] last_q, last_d;
    logic [NBITS-1:0] pending_q, pending_d;
    logic [3:0]       cnt_q [NBITS];
    logic [3:0]       cnt_d [NBITS];
    logic [2:0]       ctrl_q;
    logic             ovf_q, ovf_d;
    logic [31:0]      s_readdata_q;
    logic [31:0]      rd_data;

    logic [NBITS-1:0] emit_onehot;
    logic [3:0]       emit_idx;
    logic             changed;
    logic             push;
    logic [8:0]       push_data;
    logic             pop;
    logic [8:0]       fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [4:0]       level5;
    logic [3:0]       level_sat;
    logic             unused_ok;

    assign m_address  = 2'b00;
    assign m_read     = (state_q == POLL);
    assign s_readdata = s_readdata_q;
    assign irq        = ctrl_q[1] && !fifo_empty;
    assign tick       = ctrl_q[0] && (timer_q == '0);
    assign pop        = s_read && (s_address == REG_EVENT);
    assign level5     = 5'(fifo_level);
    assign level_sat  = (level5 > 5'd15) ? 4'hF : level5[3:0];
    assign unused_ok  = ^{m_readdata[31:NBITS], s_writedata[31:3], fifo_head[7:4], fifo_full};

    // Lowest pending bit is isolated with the two's-complement trick.
    assign emit_onehot = pending_q & (~pending_q + 1'b1);

    always_comb begin
        emit_idx = '0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (pending_q[i]) emit_idx = 4'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        last_d    = last_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        changed   = 1'b0;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            IDLE: if (tick) state_d = POLL;
            POLL: state_d = WAIT;
            WAIT: state_d = CAPT;
            CAPT: begin
                for (int i = 0; i < NBITS; i++) begin
                    last_d[i] = m_readdata[i];
                    if (m_readdata[i] != last_q[i])
                        cnt_d[i] = 4'd1;
                    else if (cnt_q[i] != CNT_MAX)
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    if (cnt_d[i] == CNT_MAX && m_readdata[i] != stable_q[i]) begin
                        stable_d[i] = m_readdata[i];
                        changed     = 1'b1;
                        if (m_readdata[i] || !ctrl_q[2]) pending_d[i] = 1'b1;
                    end
                end
                state_d = changed ? EMIT : IDLE;
            end
            EMIT: begin
                if (pending_q != '0) begin
                    push      = 1'b1;
                    push_data = {~|(stable_q & emit_onehot), 4'b0000, emit_idx};
                    pending_d = pending_q & ~emit_onehot;
                end
                if (pending_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (s_write && s_address == REG_STATUS && s_writedata[1]) ovf_d = 1'b0;
        if (fifo_drop) ovf_d = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        case (s_address)
            REG_STATUS: begin
                rd_data[0]          = !fifo_empty;
                rd_data[1]          = ovf_q;
                rd_data[7:4]        = level_sat;
                rd_data[16 +: NBITS] = stable_q;
            end
            REG_EVENT: begin
                if (!fifo_empty) begin
                    rd_data[EVT_VALID]       = 1'b1;
                    rd_data[EVT_TYPE]        = fifo_head[8];
                    rd_data[EVT_IDX_W-1:0]   = fifo_head[3:0];
                end
            end
            REG_CTRL: rd_data[2:0] = ctrl_q;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            timer_q      <= TW'(POLL_DIV - 1);
            stable_q     <= '0;
            last_q       <= '0;
            pending_q    <= '0;
            for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
            ctrl_q       <= 3'b001;
            ovf_q        <= 1'b0;
            s_readdata_q <= '0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            // Timer holds its value while disabled and resumes from there.
            if (ctrl_q[0]) timer_q <= (timer_q == '0) ? TW'(POLL_DIV - 1) : timer_q - 1'b1;
            if (s_write && s_address == REG_CTRL) ctrl_q <= s_writedata[2:0];
            if (s_read) s_readdata_q <= rd_data;
        end
    end

    scan_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop),
        .level_o (fifo_level)
    );

endmodule
